// File: rtl/seg_reader.sv
// Samples an active-low multiplexed seven-segment bus and decodes each stable glyph to a hex nibble per digit.
// Updates land on the edge that completes a STABLE_CYCLES run; events leave through a one-entry valid/ready buffer.
module seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_n,
  input  logic [1:0]  dig_sel,
  output logic [15:0] digits,
  output logic [3:0]  dig_valid,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [1:0]  upd_idx,
  output logic [3:0]  upd_val,
  output logic        upd_bad,
  output logic        err_illegal,
  output logic        err_overrun
);
  localparam logic [3:0] CNT_SAT = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_ACC = 4'(STABLE_CYCLES - 1);

  logic [8:0]  prev_q, prev_d;
  logic        prev_vld_q, prev_vld_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dig_valid_q, dig_valid_d;
  logic        upd_valid_q, upd_valid_d;
  logic [1:0]  upd_idx_q, upd_idx_d;
  logic [3:0]  upd_val_q, upd_val_d;
  logic        upd_bad_q, upd_bad_d;
  logic        err_illegal_q, err_illegal_d;
  logic        err_overrun_q, err_overrun_d;

  logic [8:0]  samp;
  logic        same, accept, glyph_legal, glyph_blank, ev_gen, ev_load;
  logic [3:0]  glyph_val;

  always_comb begin
    glyph_legal = 1'b1;
    glyph_blank = 1'b0;
    glyph_val   = 4'h0;
    case (seg_n)
      7'h40: glyph_val = 4'h0;
      7'h79: glyph_val = 4'h1;
      7'h24: glyph_val = 4'h2;
      7'h30: glyph_val = 4'h3;
      7'h19: glyph_val = 4'h4;
      7'h12: glyph_val = 4'h5;
      7'h02: glyph_val = 4'h6;
      7'h78: glyph_val = 4'h7;
      7'h00: glyph_val = 4'h8;
      7'h18: glyph_val = 4'h9;
      7'h08: glyph_val = 4'hA;
      7'h03: glyph_val = 4'hB;
      7'h46: glyph_val = 4'hC;
      7'h21: glyph_val = 4'hD;
      7'h06: glyph_val = 4'hE;
      7'h0E: glyph_val = 4'hF;
      7'h7F: begin glyph_legal = 1'b0; glyph_blank = 1'b1; end
      default: glyph_legal = 1'b0;
    endcase
  end

  always_comb begin
    samp = {dig_sel, seg_n};
    // prev_vld_q stands in for the 0x1FF sentinel, which would otherwise alias digit 3 showing blank
    same       = prev_vld_q && (samp == prev_q);
    prev_d     = samp;
    prev_vld_d = 1'b1;
    cnt_d      = same ? ((cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 4'd1) : 4'd1;
    accept     = same && (cnt_q == CNT_ACC);

    digits_d      = digits_q;
    dig_valid_d   = dig_valid_q;
    err_illegal_d = err_illegal_q;
    err_overrun_d = err_overrun_q;
    if (accept) begin
      dig_valid_d[dig_sel] = glyph_legal;
      if (glyph_legal) digits_d[{dig_sel, 2'b00} +: 4] = glyph_val;
      if (!glyph_legal && !glyph_blank) err_illegal_d = 1'b1;
    end

    ev_gen  = accept && !glyph_blank;
    ev_load = ev_gen && (!upd_valid_q || upd_ready);
    if (ev_gen && !ev_load) err_overrun_d = 1'b1;

    upd_valid_d = upd_valid_q && !upd_ready;
    upd_idx_d   = upd_idx_q;
    upd_val_d   = upd_val_q;
    upd_bad_d   = upd_bad_q;
    if (ev_load) begin
      upd_valid_d = 1'b1;
      upd_idx_d   = dig_sel;
      upd_val_d   = glyph_legal ? glyph_val : 4'h0;
      upd_bad_d   = !glyph_legal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q        <= 9'h1FF;
      prev_vld_q    <= 1'b0;
      cnt_q         <= 4'd0;
      digits_q      <= 16'h0;
      dig_valid_q   <= 4'h0;
      upd_valid_q   <= 1'b0;
      upd_idx_q     <= 2'd0;
      upd_val_q     <= 4'h0;
      upd_bad_q     <= 1'b0;
      err_illegal_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      prev_vld_q    <= prev_vld_d;
      cnt_q         <= cnt_d;
      digits_q      <= digits_d;
      dig_valid_q   <= dig_valid_d;
      upd_valid_q   <= upd_valid_d;
      upd_idx_q     <= upd_idx_d;
      upd_val_q     <= upd_val_d;
      upd_bad_q     <= upd_bad_d;
      err_illegal_q <= err_illegal_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign digits      = digits_q;
  assign dig_valid   = dig_valid_q;
  assign upd_valid   = upd_valid_q;
  assign upd_idx     = upd_idx_q;
  assign upd_val     = upd_val_q;
  assign upd_bad     = upd_bad_q;
  assign err_illegal = err_illegal_q;
  assign err_overrun = err_overrun_q;
endmodule

// File: tb/tb_seg_reader.sv
// Bench for seg_reader: directed scenarios with literal expectations, then random stimulus,
// all checked every cycle against a sample-history model of the display reader.
module tb_seg_reader;
  localparam int S = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg_n = 7'h00;
  logic [1:0]  dig_sel = 2'd0;
  logic        upd_ready = 1'b0;
  logic [15:0] digits;
  logic [3:0]  dig_valid;
  logic        upd_valid, upd_bad, err_illegal, err_overrun;
  logic [1:0]  upd_idx;
  logic [3:0]  upd_val;

  int checks = 0;
  int failures = 0;

  seg_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .dig_sel(dig_sel),
    .digits(digits), .dig_valid(dig_valid), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_idx(upd_idx), .upd_val(upd_val), .upd_bad(upd_bad),
    .err_illegal(err_illegal), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of raw samples since reset, digit table, one pending event.
  logic [8:0] hist[$];
  logic [3:0] m_dig [4];
  logic [3:0] m_dv;
  logic       m_pend, m_bad, m_ill, m_ovr, m_take;
  logic [1:0] m_idx;
  logic [3:0] m_val;
  int         m_code;

  function automatic bit run_done();
    int n = hist.size();
    if (n < S) return 1'b0;
    for (int i = n - S + 1; i < n; i++)
      if (hist[i] != hist[n-S]) return 1'b0;
    if (n == S) return 1'b1;
    return hist[n-S-1] != hist[n-S];
  endfunction

  // returns 0..15 for a legal glyph, 16 for blank, -1 for illegal
  function automatic int glyph_code(input logic [6:0] g);
    if (g == 7'h7F) return 16;
    for (int i = 0; i < 16; i++) if (GLYPH[i] == g) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
      m_dv = 4'h0; m_pend = 1'b0; m_idx = 2'd0; m_val = 4'h0; m_bad = 1'b0;
      m_ill = 1'b0; m_ovr = 1'b0;
    end else begin
      hist.push_back({dig_sel, seg_n});
      if (hist.size() > S + 1) void'(hist.pop_front());
      m_take = !m_pend || upd_ready;
      if (m_pend && upd_ready) m_pend = 1'b0;
      if (run_done()) begin
        m_code = glyph_code(seg_n);
        if (m_code == 16) begin
          m_dv[dig_sel] = 1'b0;
        end else begin
          if (m_code >= 0) begin
            m_dig[dig_sel] = 4'(m_code);
            m_dv[dig_sel]  = 1'b1;
          end else begin
            m_dv[dig_sel] = 1'b0;
            m_ill = 1'b1;
          end
          if (m_take) begin
            m_pend = 1'b1; m_idx = dig_sel;
            m_val = (m_code >= 0) ? 4'(m_code) : 4'h0;
            m_bad = (m_code < 0);
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("state", {32'h0, digits, dig_valid, upd_valid, err_illegal, err_overrun},
          {32'h0, m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_dv, m_pend, m_ill, m_ovr});
    if (m_pend || reset)
      check("payload", {57'h0, upd_idx, upd_val, upd_bad}, {57'h0, m_idx, m_val, m_bad});
  end

  logic [6:0] hs_log[$];
  always @(posedge clk)
    if (!reset && upd_valid && upd_ready) hs_log.push_back({upd_idx, upd_val, upd_bad});

  task automatic drive(input logic [1:0] s, input logic [6:0] g, input int rdy, input int n);
    for (int k = 0; k < n; k++) begin
      dig_sel = s;
      seg_n = g;
      upd_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy != 0);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_outputs_reset();
    check("rst_digits", 64'(digits), 64'h0);
    check("rst_flags", {57'h0, dig_valid, upd_valid, err_illegal, err_overrun}, 64'h0);
    check("rst_payload", {57'h0, upd_idx, upd_val, upd_bad}, 64'h0);
  endtask

  logic [6:0] g;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check_outputs_reset();
    reset = 1'b0;

    // Basic acceptance on digit 2, then no re-fire
    drive(2'd2, 7'h30, 1, 3);
    check("t1_early", 64'(upd_valid), 64'h0);
    drive(2'd2, 7'h30, 1, 1);
    check("t1_digit", 64'(digits[11:8]), 64'h3);
    check("t1_dv", 64'(dig_valid), 64'b0100);
    check("t1_evt", {57'h0, upd_valid, upd_idx, upd_val, upd_bad}, {57'h0, 1'b1, 2'd2, 4'd3, 1'b0});
    drive(2'd2, 7'h30, 1, 5);
    check("t1_nofire", 64'(upd_valid), 64'h0);

    // Glitch restarts the run
    drive(2'd1, 7'h18, 1, 3);
    drive(2'd1, 7'h10, 1, 1);
    drive(2'd1, 7'h18, 1, 3);
    check("t2_early", 64'(upd_valid), 64'h0);
    drive(2'd1, 7'h18, 1, 1);
    check("t2_evt", {57'h0, upd_valid, upd_idx, upd_val, upd_bad}, {57'h0, 1'b1, 2'd1, 4'd9, 1'b0});
    check("t2_ill", 64'(err_illegal), 64'h0);

    // Illegal glyph
    drive(2'd0, 7'h7E, 1, 4);
    check("t3_evt", {57'h0, upd_valid, upd_idx, upd_val, upd_bad}, {57'h0, 1'b1, 2'd0, 4'd0, 1'b1});
    check("t3_ill", 64'(err_illegal), 64'h1);
    check("t3_dv", 64'(dig_valid), 64'b0110);
    check("t3_dig", 64'(digits[3:0]), 64'h0);

    // Blank keeps the nibble but invalidates it
    drive(2'd3, 7'h0E, 1, 4);
    check("t4_F", 64'(digits[15:12]), 64'hF);
    drive(2'd3, 7'h7F, 1, 4);
    check("t4_dv", 64'(dig_valid[3]), 64'h0);
    check("t4_dig", 64'(digits[15:12]), 64'hF);
    check("t4_noevt", 64'(upd_valid), 64'h0);

    // Backpressure and overrun
    drive(2'd0, 7'h40, 0, 4);
    drive(2'd1, 7'h79, 0, 4);
    check("t5_ovr", 64'(err_overrun), 64'h1);
    check("t5_dig1", 64'(digits[7:4]), 64'h1);
    check("t5_pend", {57'h0, upd_valid, upd_idx, upd_val, upd_bad}, {57'h0, 1'b1, 2'd0, 4'd0, 1'b0});
    hs_log.delete();
    drive(2'd1, 7'h79, 1, 3);
    check("t5_xfers", 64'(hs_log.size()), 64'd1);
    if (hs_log.size() > 0) check("t5_xfer", 64'(hs_log[0]), 64'h0);

    // Sweep all glyphs round-robin, back-to-back
    hs_log.delete();
    for (int i = 0; i < 16; i++) drive(2'(i % 4), GLYPH[i], 1, 4);
    drive(2'd3, GLYPH[15], 1, 1);
    check("t6_count", 64'(hs_log.size()), 64'd16);
    for (int i = 0; i < 16 && i < hs_log.size(); i++)
      check("t6_evt", 64'(hs_log[i]), 64'({2'(i % 4), 4'(i), 1'b0}));

    // Reset mid-run, then a full run is needed again
    drive(2'd2, 7'h24, 1, 2);
    reset = 1'b1;
    #1;
    check_outputs_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    drive(2'd2, 7'h24, 1, 3);
    check("t7_early", 64'(upd_valid), 64'h0);
    drive(2'd2, 7'h24, 1, 1);
    check("t7_evt", {57'h0, upd_valid, upd_idx, upd_val}, {57'h0, 1'b1, 2'd2, 4'd2});

    // Random traffic against the model
    for (int r = 0; r < 250; r++) begin
      case ($urandom_range(0, 9))
        0:       g = 7'h7F;
        1, 2:    g = 7'($urandom);
        default: g = GLYPH[$urandom_range(0, 15)];
      endcase
      drive(2'($urandom_range(0, 3)), g, 2, $urandom_range(1, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_reader.md
# seg_reader

Receive-side counterpart of the board's hex-to-seven-segment driver. It samples a time-multiplexed, active-low seven-segment bus, consisting of the segment lines plus a digit-select code, and waits until each pattern has been stable for a set number of cycles. It then decodes the glyph back to a 4-bit hex value and stores it per digit. It offers each decoded update to a downstream consumer over a valid/ready handshake. Uses: display loop-back self-test, and recovering score/state digits from a neighbouring board's display harness.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a pattern; legal range 2..15.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- seg_n  in  7  segment lines, active-low (0 = lit); bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- dig_sel  in  2  index of the digit currently driven (0..3).
- digits  out  16  decoded nibbles; digit i at [4i+3:4i].
- dig_valid  out  4  bit i = digits[i] holds a legal decoded glyph.
- upd_valid  out  1  update event pending.
- upd_ready  in  1  consumer accepts the event when high with upd_valid.
- upd_idx  out  2  digit index of the pending event.
- upd_val  out  4  decoded value of the pending event (0 when upd_bad).
- upd_bad  out  1  pending event is an illegal pattern.
- err_illegal  out  1  sticky: an illegal pattern was accepted.
- err_overrun  out  1  sticky: an event was dropped because one was already pending.

## Operation
- Legal glyphs, as seg_n[6:0] hex → value:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7
  - 0x00→8, 0x18→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F
  - 0x7F = blank.
  - Any other pattern is illegal.
- Stability tracker:
  - Register prev = {dig_sel, seg_n}, plus run counter cnt (4 bits, saturates at STABLE_CYCLES).
  - Each edge: if the input equals prev, cnt <= sat(cnt+1); otherwise cnt <= 1. prev <= input.
- Acceptance fires on the edge where the input equals prev and cnt == STABLE_CYCLES-1. It fires exactly once per stable run; a run longer than STABLE_CYCLES does not re-fire. Any change to seg_n or dig_sel restarts the run.
- On acceptance, at digit d = dig_sel:
  - Legal glyph v: digits[d] <= v, dig_valid[d] <= 1, event {d, v, bad=0} generated.
  - Blank: dig_valid[d] <= 0, digits[d] unchanged, no event.
  - Illegal: dig_valid[d] <= 0, digits[d] unchanged, err_illegal <= 1, event {d, 0, bad=1} generated.
- Event output is a single-entry buffer:
  - A generated event loads the buffer if it is empty, or if upd_valid & upd_ready on the same edge (pop-and-load).
  - Otherwise the new event is dropped, err_overrun <= 1, and the buffered event is kept.
  - Digit registers update regardless of drops.
- upd_idx, upd_val and upd_bad stay stable while upd_valid is high and not yet accepted.
- err flags clear only on reset.

## Timing
- Reset values:
  - digits = 0, dig_valid = 0, upd_valid = 0, upd_idx = 0, upd_val = 0, upd_bad = 0, err_illegal = 0, err_overrun = 0.
  - cnt = 0, prev = 0x1FF sentinel, treated as unequal to any input.
- Latency: the input is held constant across edges k..k+STABLE_CYCLES-1. digits, dig_valid and upd_valid change immediately after edge k+STABLE_CYCLES-1, with no extra pipeline stage.
- Handshake: the transfer completes on an edge with upd_valid & upd_ready. upd_valid drops after that edge unless a new event loads on the same edge.
- upd_ready held high gives back-to-back events with no bubble cycles.
- Reset asserted mid-run discards the partial run and any pending event. The first acceptance after release needs a full STABLE_CYCLES run measured from the first post-reset edge.
- The first post-reset sample always starts a run with cnt = 1.

## Test plan
- Reset, STABLE_CYCLES=4, then hold dig_sel=2, seg_n=0x30 for 4 edges with upd_ready=1. Required: after the 4th edge digits[11:8]=3, dig_valid=0100, and upd_valid high for one cycle with upd_idx=2, upd_val=3, upd_bad=0. The held value must not re-fire.
- Glitch: seg_n=0x18 for 3 edges, 0x10 for 1 edge, then 0x18 for 4 edges on dig_sel=1. Required: one event only, val=9, after the final 4-run; 0x10 run too short, so err_illegal stays 0.
- Illegal: hold 0x7E on dig_sel=0 for 4 edges. Required: upd_bad=1, upd_val=0, err_illegal=1, dig_valid[0]=0, digits[3:0] unchanged.
- Blank: after digit 3 shows 0x0E (F), hold 0x7F. Required: dig_valid[3]=0, digits[15:12]=F, no event.
- Backpressure: upd_ready=0, accept 0x40 on digit 0, then 0x79 on digit 1. Required: the pending event stays {0,0}, err_overrun=1, digits[7:4]=1; raising upd_ready transfers {0,0} once.
- Sweep all 16 legal glyphs round-robin over digits 0..3 with upd_ready=1, then assert reset mid-run. Required: 16 events with matching values in order; all outputs return to reset values.
